// File: rtl/abr_params_pkg.sv
// ML-DSA arithmetic constants shared by the Adams Bridge datapath blocks.
package abr_params_pkg;

    localparam int REG_SIZE     = 24;
    localparam int Q            = 8380417;
    localparam int GAMMA1       = 524288;
    localparam int BETA         = 120;
    localparam int MLDSA_GAMMA2 = (Q - 1) / 32;

endpackage

// File: rtl/norm_check_defines_pkg.sv
// Types and geometry shared between norm_check and the polynomial scanner.
package norm_check_defines_pkg;

    typedef enum logic [1:0] {
        Z_BOUND   = 2'b00,
        R0_BOUND  = 2'b01,
        CT0_BOUND = 2'b10
    } chk_norm_mode_t;

    localparam int COEFF_PER_WORD = 4;
    localparam int WORDS_PER_POLY = 64;

endpackage

// File: rtl/norm_check_scan_pkg.sv
// Scanner-local sizing and FSM state encoding.
package norm_check_scan_pkg;

    localparam int MEM_ADDR_WIDTH = 15;
    localparam int MAX_POLY       = 8;
    localparam int CNT_W          = $clog2(MAX_POLY * norm_check_defines_pkg::WORDS_PER_POLY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } scan_state_e;

endpackage

// File: rtl/norm_check.sv
// One-coefficient infinity-norm check: flags c whose centred magnitude
// reaches the selected bound, i.e. bound <= c <= Q - bound.
module norm_check
    import abr_params_pkg::*;
    import norm_check_defines_pkg::*;
(
    input  logic                  enable,
    input  chk_norm_mode_t        mode,
    input  logic [REG_SIZE-2:0]   opa,
    output logic                  invalid
);

    localparam logic [REG_SIZE-2:0] Q_W = (REG_SIZE-1)'(Q);

    logic [REG_SIZE-2:0] bound_s;

    // Unencoded modes fall to a zero bound so every coefficient is rejected.
    always_comb begin
        case (mode)
            Z_BOUND:   bound_s = (REG_SIZE-1)'(GAMMA1 - BETA);
            R0_BOUND:  bound_s = (REG_SIZE-1)'(MLDSA_GAMMA2 - BETA);
            CT0_BOUND: bound_s = (REG_SIZE-1)'(MLDSA_GAMMA2);
            default:   bound_s = '0;
        endcase
    end

    assign invalid = enable && (opa >= bound_s) && (opa <= (Q_W - bound_s));

endmodule

// File: rtl/norm_check_scan.sv
// Streams whole polynomials through four norm_check lanes and folds the
// lane verdicts into one sticky invalid flag; run length depends only on num_poly.
module norm_check_scan
    import abr_params_pkg::*;
    import norm_check_defines_pkg::*;
    import norm_check_scan_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               zeroize,
    input  logic                               start,
    input  chk_norm_mode_t                     mode,
    input  logic [MEM_ADDR_WIDTH-1:0]          mem_base_addr,
    input  logic [3:0]                         num_poly,
    output logic                               mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0]          mem_rd_addr,
    input  logic [COEFF_PER_WORD*REG_SIZE-1:0] mem_rd_data,
    output logic                               busy,
    output logic                               done,
    output logic                               invalid
);

    scan_state_e                state_q;
    chk_norm_mode_t             mode_q;
    logic [MEM_ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_W-1:0]           n_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       drain_q;
    logic                       rd_en_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       rd_vld_q;
    logic                       lane_or_q;
    logic                       invalid_q;

    logic [3:0]                 np_d;
    logic [CNT_W-1:0]           n_d;
    logic                       start_acc_d;
    logic                       lane_or_d;
    logic [COEFF_PER_WORD-1:0]  lane_inv_s;
    logic [COEFF_PER_WORD-1:0]  unused_msb_s;

    // Request decode: clamp the polynomial count and qualify start by IDLE.
    always_comb begin
        np_d        = (num_poly > 4'(MAX_POLY)) ? 4'(MAX_POLY) : num_poly;
        n_d         = CNT_W'(np_d) * CNT_W'(WORDS_PER_POLY);
        start_acc_d = start && (state_q == ST_IDLE);
        lane_or_d   = |lane_inv_s;
    end

    // Scan sequencer: fixed-length read burst, two drain cycles, done pulse.
    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            state_q <= ST_IDLE;
            mode_q  <= Z_BOUND;
            addr_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_d) begin
                        mode_q <= mode;
                        addr_q <= mem_base_addr;
                        n_q    <= n_d;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (n_d == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (cnt_q == (n_q - CNT_W'(1))) begin
                        rd_en_q <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < COEFF_PER_WORD; i++) begin : g_lane
        norm_check u_norm_check (
            .enable  (rd_vld_q),
            .mode    (mode_q),
            .opa     (mem_rd_data[i*REG_SIZE +: REG_SIZE-1]),
            .invalid (lane_inv_s[i])
        );
        assign unused_msb_s[i] = mem_rd_data[i*REG_SIZE + REG_SIZE-1];
    end

    // Data pipe: read-valid delay, registered lane OR, sticky verdict.
    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            rd_vld_q  <= 1'b0;
            lane_or_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en_q;
            lane_or_q <= lane_or_d;
            if (start_acc_d) begin
                invalid_q <= 1'b0;
            end else begin
                invalid_q <= invalid_q | lane_or_q;
            end
        end
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign invalid     = invalid_q;

endmodule

// File: tb/tb_norm_check_scan.sv
// Directed bench for norm_check_scan: a memory model answers reads, and a
// scoreboard of expected addresses and verdicts is checked by a monitor.
module tb_norm_check_scan;
    import abr_params_pkg::*;
    import norm_check_defines_pkg::*;
    import norm_check_scan_pkg::*;

    localparam int DW = COEFF_PER_WORD * REG_SIZE;

    logic                      clk = 1'b0;
    logic                      reset, zeroize, start;
    chk_norm_mode_t            mode;
    logic [MEM_ADDR_WIDTH-1:0] mem_base_addr;
    logic [3:0]                num_poly;
    logic                      mem_rd_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DW-1:0]             mem_rd_data;
    logic                      busy, done, invalid;

    norm_check_scan dut (
        .clk(clk), .reset(reset), .zeroize(zeroize), .start(start), .mode(mode),
        .mem_base_addr(mem_base_addr), .num_poly(num_poly),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .done(done), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct { bit inv; int done_rel; int busy_len; } exp_t;
    exp_t        exp_q[$];
    logic [14:0] addr_exp_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0, busy_cnt = 0;
    logic [14:0] hot_addr = 15'd0;
    int          hot_lane = 0;
    int          hot_val  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_at(input logic [14:0] a);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < COEFF_PER_WORD; i++) w[i*REG_SIZE + REG_SIZE-1] = 1'b1;
        if (a == hot_addr && hot_val != 0) w[hot_lane*REG_SIZE +: 23] = 23'(hot_val);
        return w;
    endfunction

    function automatic logic [DW-1:0] garbage_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < COEFF_PER_WORD; i++) w[i*REG_SIZE +: 24] = 24'd524168;
        return w;
    endfunction

    // Reference: centred magnitude against the ML-DSA bound for each mode.
    function automatic bit coeff_bad(input int m, input int c);
        int v, b;
        v = (c > 4190208) ? (8380417 - c) : c;
        case (m)
            0:       b = 524168;
            1:       b = 261768;
            2:       b = 261888;
            default: b = 0;
        endcase
        return v >= b;
    endfunction

    // Memory: data returns one cycle after a read, junk otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= word_at(mem_rd_addr);
        else           mem_rd_data <= garbage_word();
    end

    // Monitor: address stream, busy length, done timing and verdict.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            check("rd_expected", 32'(addr_exp_q.size() > 0), 32'd1);
            if (addr_exp_q.size() > 0) check("rd_addr", 32'(mem_rd_addr), 32'(addr_exp_q.pop_front()));
        end
        if (busy) busy_cnt++;
        if (done) begin
            exp_t e;
            done_cnt++;
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("invalid", 32'(invalid), 32'(e.inv));
                check("done_cycle", 32'(cyc - start_cyc), 32'(e.done_rel));
                check("busy_len", 32'(busy_cnt), 32'(e.busy_len));
                check("reads_left", 32'(addr_exp_q.size()), 32'd0);
            end
            busy_cnt = 0;
        end
    end

    task automatic run_scan(input chk_norm_mode_t m, input logic [14:0] base,
                            input logic [3:0] np, input int restart_at);
        int  n, off, d0;
        bit  inv;
        n   = ((np > 4'd8) ? 8 : int'(np)) * 64;
        for (int i = 0; i < n; i++) addr_exp_q.push_back(15'(int'(base) + i));
        off = (int'(hot_addr) - int'(base) + 32768) % 32768;
        inv = (n > 0) && (coeff_bad(int'(m), 0) ||
                          (hot_val != 0 && off < n && coeff_bad(int'(m), hot_val)));
        exp_q.push_back('{inv, (n == 0) ? 1 : n + 3, (n == 0) ? 1 : n + 3});
        @(negedge clk); #1;
        mode = m; mem_base_addr = base; num_poly = np; start = 1'b1;
        start_cyc = cyc; busy_cnt = 0; d0 = done_cnt;
        for (int c = 1; c <= n + 20; c++) begin
            @(negedge clk); #1;
            if (c == restart_at) begin
                start = 1'b1; mode = CT0_BOUND; mem_base_addr = 15'h1234; num_poly = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != d0) break;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("invalid_held", 32'(invalid), 32'(inv));
    endtask

    task automatic abort_scan(input bit use_zeroize);
        int d0;
        hot_addr = 15'h0200; hot_lane = 2; hot_val = 261888;
        for (int i = 0; i < 64; i++) addr_exp_q.push_back(15'(16'h0200 + i));
        @(negedge clk); #1;
        mode = CT0_BOUND; mem_base_addr = 15'h0200; num_poly = 4'd1; start = 1'b1;
        start_cyc = cyc; busy_cnt = 0; d0 = done_cnt;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (c == 29) check("pre_abort_invalid", 32'(invalid), 32'd1);
            if (c == 30) begin
                if (use_zeroize) zeroize = 1'b1; else reset = 1'b1;
                addr_exp_q.delete();
            end
            if (c == 31) begin
                reset = 1'b0; zeroize = 1'b0;
                check("abort_rd_en", 32'(mem_rd_en), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_invalid", 32'(invalid), 32'd0);
                check("abort_addr", 32'(mem_rd_addr), 32'd0);
            end
        end
        repeat (80) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        hot_val = 0;
    endtask

    initial begin
        reset = 1'b1; zeroize = 1'b0; start = 1'b0; mode = Z_BOUND;
        mem_base_addr = '0; num_poly = 4'd0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);

        run_scan(Z_BOUND, 15'h0100, 4'd1, 0);

        hot_addr = 15'd63; hot_lane = 3;
        hot_val = 524168;  run_scan(Z_BOUND, 15'h0000, 4'd1, 0);
        hot_val = 524167;  run_scan(Z_BOUND, 15'h0000, 4'd1, 0);
        hot_val = 7856249; run_scan(Z_BOUND, 15'h0000, 4'd1, 0);
        hot_val = 7856250; run_scan(Z_BOUND, 15'h0000, 4'd1, 0);

        hot_addr = 15'h7FF0; hot_lane = 0; hot_val = 261888;
        run_scan(CT0_BOUND, 15'h7FF0, 4'd8, 0);

        hot_addr = 15'd5; hot_lane = 1;
        hot_val = 261768; run_scan(R0_BOUND, 15'h0000, 4'd1, 10);
        hot_val = 261767; run_scan(R0_BOUND, 15'h0000, 4'd1, 0);

        hot_val = 0;
        run_scan(Z_BOUND, 15'h0040, 4'd0, 0);
        run_scan(chk_norm_mode_t'(2'b11), 15'h0000, 4'd1, 0);
        run_scan(Z_BOUND, 15'h4000, 4'd12, 0);

        abort_scan(1'b0);
        abort_scan(1'b1);
        run_scan(R0_BOUND, 15'h0000, 4'd1, 0);

        check("scoreboard_empty", 32'(exp_q.size() + addr_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_check_scan.md
Name: norm_check_scan

Overview:
- Sequencer that streams whole polynomials from coefficient memory through four parallel norm_check lanes.
- Produces one sticky invalid verdict per scan.
- Sits between the ML-DSA sign/verify controller and the coefficient SRAM. The controller issues start, mode, base address and polynomial count, then samples invalid on done.
- Scan time depends only on num_poly, never on data (side-channel requirement).

Parameters:
- REG_SIZE, 24, coefficient container width; coefficients in memory are REG_SIZE-1 = 23 bits.
- COEFF_PER_WORD, 4, coefficients per memory word.
- MEM_ADDR_WIDTH, 15, memory address width.
- WORDS_PER_POLY, 64, words per 256-coefficient polynomial.
- MAX_POLY, 8, maximum polynomials per scan.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- zeroize  in  1  synchronous clear; same effect as reset
- start  in  1  single-cycle scan request
- mode  in  chk_norm_mode_t (2)  bound select (z_bound / r0_bound / ct0_bound); latched at start
- mem_base_addr  in  MEM_ADDR_WIDTH  address of first word
- num_poly  in  4  polynomial count, 0..MAX_POLY
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  MEM_ADDR_WIDTH  read address
- mem_rd_data  in  COEFF_PER_WORD*REG_SIZE  read data, valid exactly 1 cycle after mem_rd_en; lane i in bits [i*REG_SIZE +: REG_SIZE-1], MSB per lane ignored
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  single-cycle completion pulse
- invalid  out  1  scan verdict; valid on done, held until the next accepted start

Behaviour:
- Reset/zeroize values: state IDLE; mem_rd_en, mem_rd_addr, busy, done, invalid, counters, latched mode and pipe valids all 0. Takes priority over every other event, including mid-scan. No done is produced for an aborted scan.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 latches mode, base address and N = num_poly*WORDS_PER_POLY, and clears invalid.
  - N>0 goes to READ; N=0 goes directly to DONE.
- READ:
  - mem_rd_en=1 every cycle.
  - mem_rd_addr = base + word counter, counting 0..N-1; address arithmetic is modulo 2^MEM_ADDR_WIDTH, no range check.
  - After issuing word N-1, go to DRAIN.
- DRAIN: exactly 2 cycles, covering data return and compare register; then DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- Timing: start sampled in cycle 0 gives reads in cycles 1..N and done in cycle N+3. For N=0, done is in cycle 1.
- Datapath, pipe stage 1:
  - A read-valid flag delayed 1 cycle qualifies mem_rd_data.
  - Four norm_check lanes run with enable = that flag and the latched mode.
  - Lane outputs are ORed and registered (stage 2).
- Datapath, pipe stage 2: the registered OR is ORed into the sticky invalid.
- No early exit: a violation in word 0 still runs all N reads and done still lands at N+3.
- start while busy is ignored; all latched values are unchanged.
- start in the DONE cycle is also ignored. start is accepted only in IDLE.
- An unencoded mode value gives bound 0 in the lanes, so every coefficient flags and invalid=1 (fail-safe).
- num_poly > MAX_POLY is clamped to MAX_POLY.
- invalid is never cleared except by an accepted start, reset or zeroize.

Decomposition:
- chk_norm_mode_t plus COEFF_PER_WORD and WORDS_PER_POLY live in norm_check_defines_pkg, shared with norm_check.
- Q, GAMMA1, BETA and MLDSA_GAMMA2 come from abr_params_pkg.
- Sub-module: four instances of the existing norm_check, one per lane.
- FSM, counters and pipe registers stay in this module; no further sub-module.

Test Plan:
- z mode, num_poly=1, all coeffs 0 -> mem_rd_en for 64 cycles at base..base+63; done in cycle 67; invalid=0; busy high cycles 1..67.
- z mode, num_poly=1: a coeff in lane 3 of word 63 set to 524168 -> invalid=1; set to 524167 -> 0; set to 7856249 -> 1; set to 7856250 -> 0.
- ct0 mode, num_poly=8, base=0x7FF0: coeff 261888 in lane 0 of word 0 -> addresses wrap to 0x0000 after 0x7FFF; invalid=1; done still in cycle 515.
- r0 mode: coeff 261768 -> 1; coeff 261767 -> 0; second start pulse in cycle 10 -> ignored, single done.
- num_poly=0 -> no mem_rd_en; done in cycle 1; invalid=0. Mode=2'b11 with all-zero data -> invalid=1.
- reset (or zeroize) asserted in cycle 30 of a scan -> next cycle IDLE, rd_en/busy/invalid=0, no done; a new start then completes normally.
